// File: rtl/uart_cfg_if.sv
// Host-side byte and configuration bus of uart_cfg.
// master = host, slave = UART.
interface uart_cfg_if #(
  parameter int DVSR_W = 16
);
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        data_bits;
  logic              parity_en;
  logic              parity_odd;
  logic              stop2;
  logic              rd_uart;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              clr_err;
  logic [7:0]        r_data;
  logic              rx_empty;
  logic              tx_full;
  logic              err_frame;
  logic              err_parity;
  logic              err_overrun;

  modport master (
    output dvsr, data_bits, parity_en, parity_odd, stop2,
    output rd_uart, wr_uart, w_data, clr_err,
    input  r_data, rx_empty, tx_full, err_frame, err_parity, err_overrun
  );

  modport slave (
    input  dvsr, data_bits, parity_en, parity_odd, stop2,
    input  rd_uart, wr_uart, w_data, clr_err,
    output r_data, rx_empty, tx_full, err_frame, err_parity, err_overrun
  );
endinterface

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: baud tick, RX/TX FSMs, RX/TX FIFOs, sticky error flags.
// Optional macro UART_LOOPBACK_EN adds a loopback input (RX listens to TX, tx pin held high).
//
// RX states   | meaning
// R_IDLE      | waiting for rx low on a tick
// R_START     | confirming start bit at its centre
// R_DATA      | sampling data bits, LSB first
// R_PAR       | sampling parity bit
// R_STOP      | sampling the (single checked) stop bit, then push
//
// TX states   | meaning
// T_IDLE      | line high, waiting for FIFO data on a tick
// T_START     | driving start bit
// T_DATA      | driving data bits, LSB first
// T_PAR       | driving parity bit
// T_STOP      | driving 1 or 2 stop bits
module uart_cfg #(
  parameter int DVSR_W = 16,
  parameter int FIFO_W = 2,
  parameter int SB_TCK = 16
) (
  input  logic       clk,
  input  logic       reset,
  uart_cfg_if.slave  bus,
  input  logic       rx,
  output logic       tx
`ifdef UART_LOOPBACK_EN
  ,
  input  logic       loopback
`endif
);

  localparam int DEPTH = 2 ** FIFO_W;
  localparam int SW    = $clog2(2 * SB_TCK);
  localparam logic [SW-1:0]     S_HALF   = SW'(SB_TCK / 2 - 2);
  localparam logic [SW-1:0]     S_LAST   = SW'(SB_TCK - 1);
  localparam logic [SW-1:0]     S_LAST2  = SW'(2 * SB_TCK - 1);
  localparam logic [FIFO_W:0]   FULL_CNT = (FIFO_W + 1)'(DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  // ---------------- baud tick ----------------
  logic [DVSR_W-1:0] tck_cnt;
  logic [DVSR_W-1:0] tck_lim;
  logic [DVSR_W-1:0] dvsr_eff;
  logic              tick;

  assign dvsr_eff = (bus.dvsr == '0) ? DVSR_W'(1) : bus.dvsr;
  assign tick     = (tck_cnt == tck_lim - DVSR_W'(1));

  // The limit is only reloaded at the wrap so a dvsr change never truncates a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      tck_cnt <= '0;
      tck_lim <= dvsr_eff;
    end else if (tick) begin
      tck_cnt <= '0;
      tck_lim <= dvsr_eff;
    end else begin
      tck_cnt <= tck_cnt + 1'b1;
    end
  end

  // ---------------- serial path selection ----------------
  logic rx_meta;
  logic rx_sync;
  logic rx_in;
  logic tx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_reg : rx_sync;
  assign tx    = loopback ? 1'b1 : tx_reg;
`else
  assign rx_in = rx_sync;
  assign tx    = tx_reg;
`endif

  // ---------------- RX FSM ----------------
  rx_state_t   rx_state;
  logic [SW-1:0] rx_s;
  logic [2:0]  rx_n;
  logic [7:0]  rx_shreg;
  logic        rx_par;
  logic [1:0]  rx_nb;
  logic        rx_pe;
  logic        rx_po;
  logic        rx_push;
  logic        par_evt;
  logic        frm_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= R_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_shreg <= '0;
      rx_par   <= 1'b0;
      rx_nb    <= '0;
      rx_pe    <= 1'b0;
      rx_po    <= 1'b0;
      rx_push  <= 1'b0;
      par_evt  <= 1'b0;
      frm_evt  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      par_evt <= 1'b0;
      frm_evt <= 1'b0;
      if (tick) begin
        case (rx_state)
          R_IDLE: begin
            if (!rx_in) begin
              rx_state <= R_START;
              rx_s     <= '0;
              rx_nb    <= bus.data_bits;
              rx_pe    <= bus.parity_en;
              rx_po    <= bus.parity_odd;
            end
          end
          R_START: begin
            if (rx_s == S_HALF) begin
              rx_s     <= '0;
              rx_n     <= '0;
              rx_shreg <= '0;
              rx_par   <= 1'b0;
              rx_state <= rx_in ? R_IDLE : R_DATA;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
          R_DATA: begin
            if (rx_s == S_LAST) begin
              rx_s           <= '0;
              rx_shreg[rx_n] <= rx_in;
              rx_par         <= rx_par ^ rx_in;
              // last bit index is 4 + data_bits
              if (rx_n == {1'b1, rx_nb}) rx_state <= rx_pe ? R_PAR : R_STOP;
              else                       rx_n     <= rx_n + 1'b1;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
          R_PAR: begin
            if (rx_s == S_LAST) begin
              rx_s     <= '0;
              par_evt  <= ((rx_par ^ rx_in) != rx_po);
              rx_state <= R_STOP;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
          R_STOP: begin
            if (rx_s == S_LAST) begin
              rx_s     <= '0;
              frm_evt  <= !rx_in;
              rx_push  <= 1'b1;
              rx_state <= R_IDLE;
            end else begin
              rx_s <= rx_s + 1'b1;
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]        rxf_mem [DEPTH];
  logic [FIFO_W-1:0] rxf_wp;
  logic [FIFO_W-1:0] rxf_rp;
  logic [FIFO_W:0]   rxf_cnt;
  logic              rxf_empty;
  logic              rxf_full;
  logic              rxf_rd;
  logic              rxf_wr;

  assign rxf_empty = (rxf_cnt == '0);
  assign rxf_full  = (rxf_cnt == FULL_CNT);
  assign rxf_rd    = bus.rd_uart && !rxf_empty;
  assign rxf_wr    = rx_push && (!rxf_full || rxf_rd);

  always_ff @(posedge clk) begin
    if (rxf_wr) rxf_mem[rxf_wp] <= rx_shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxf_wp  <= '0;
      rxf_rp  <= '0;
      rxf_cnt <= '0;
    end else begin
      if (rxf_wr) rxf_wp <= rxf_wp + 1'b1;
      if (rxf_rd) rxf_rp <= rxf_rp + 1'b1;
      case ({rxf_wr, rxf_rd})
        2'b10:   rxf_cnt <= rxf_cnt + 1'b1;
        2'b01:   rxf_cnt <= rxf_cnt - 1'b1;
        default: rxf_cnt <= rxf_cnt;
      endcase
    end
  end

  assign bus.r_data   = rxf_empty ? 8'h00 : rxf_mem[rxf_rp];
  assign bus.rx_empty = rxf_empty;

  // ---------------- TX FIFO ----------------
  logic [7:0]        txf_mem [DEPTH];
  logic [FIFO_W-1:0] txf_wp;
  logic [FIFO_W-1:0] txf_rp;
  logic [FIFO_W:0]   txf_cnt;
  logic              txf_empty;
  logic              txf_full;
  logic              tx_pop;
  logic              txf_wr;
  logic [7:0]        tx_head;

  assign txf_empty = (txf_cnt == '0);
  assign txf_full  = (txf_cnt == FULL_CNT);
  assign txf_wr    = bus.wr_uart && (!txf_full || tx_pop);
  assign tx_head   = txf_mem[txf_rp];

  always_ff @(posedge clk) begin
    if (txf_wr) txf_mem[txf_wp] <= bus.w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txf_wp  <= '0;
      txf_rp  <= '0;
      txf_cnt <= '0;
    end else begin
      if (txf_wr) txf_wp <= txf_wp + 1'b1;
      if (tx_pop) txf_rp <= txf_rp + 1'b1;
      case ({txf_wr, tx_pop})
        2'b10:   txf_cnt <= txf_cnt + 1'b1;
        2'b01:   txf_cnt <= txf_cnt - 1'b1;
        default: txf_cnt <= txf_cnt;
      endcase
    end
  end

  assign bus.tx_full = txf_full;

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state;
  logic [SW-1:0] tx_s;
  logic [2:0]    tx_n;
  logic [7:0]    tx_shreg;
  logic [1:0]    tx_nb;
  logic          tx_pe;
  logic          tx_pbit;
  logic          tx_stop2;
  logic [7:0]    tx_mask;
  logic          tx_frame_end;

  assign tx_mask      = 8'hFF >> (~bus.data_bits);
  assign tx_frame_end = (tx_state == T_STOP) && (tx_s == (tx_stop2 ? S_LAST2 : S_LAST));
  // A frame ending with data pending starts the next one on the same tick: no idle gap.
  assign tx_pop       = tick && !txf_empty && ((tx_state == T_IDLE) || tx_frame_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= T_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_shreg <= '0;
      tx_nb    <= '0;
      tx_pe    <= 1'b0;
      tx_pbit  <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_reg   <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= T_START;
      tx_s     <= '0;
      tx_shreg <= tx_head;
      tx_nb    <= bus.data_bits;
      tx_pe    <= bus.parity_en;
      tx_pbit  <= (^(tx_head & tx_mask)) ^ bus.parity_odd;
      tx_stop2 <= bus.stop2;
      tx_reg   <= 1'b0;
    end else if (tick) begin
      case (tx_state)
        T_IDLE: tx_reg <= 1'b1;
        T_START: begin
          if (tx_s == S_LAST) begin
            tx_s     <= '0;
            tx_n     <= '0;
            tx_state <= T_DATA;
            tx_reg   <= tx_shreg[0];
          end else begin
            tx_s <= tx_s + 1'b1;
          end
        end
        T_DATA: begin
          if (tx_s == S_LAST) begin
            tx_s     <= '0;
            tx_shreg <= tx_shreg >> 1;
            if (tx_n == {1'b1, tx_nb}) begin
              tx_state <= tx_pe ? T_PAR : T_STOP;
              tx_reg   <= tx_pe ? tx_pbit : 1'b1;
            end else begin
              tx_n   <= tx_n + 1'b1;
              tx_reg <= tx_shreg[1];
            end
          end else begin
            tx_s <= tx_s + 1'b1;
          end
        end
        T_PAR: begin
          if (tx_s == S_LAST) begin
            tx_s     <= '0;
            tx_state <= T_STOP;
            tx_reg   <= 1'b1;
          end else begin
            tx_s <= tx_s + 1'b1;
          end
        end
        T_STOP: begin
          if (tx_frame_end) begin
            tx_s     <= '0;
            tx_state <= T_IDLE;
          end else begin
            tx_s <= tx_s + 1'b1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // ---------------- sticky errors: a new event beats clr_err ----------------
  logic err_frame_q;
  logic err_parity_q;
  logic err_overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_frame_q   <= frm_evt | (err_frame_q & ~bus.clr_err);
      err_parity_q  <= par_evt | (err_parity_q & ~bus.clr_err);
      err_overrun_q <= (rx_push & ~rxf_wr) | (err_overrun_q & ~bus.clr_err);
    end
  end

  assign bus.err_frame   = err_frame_q;
  assign bus.err_parity  = err_parity_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: RX bytes checked by a scoreboard monitor, TX waveform checked per bit.
module tb_uart_cfg;
  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;
`ifdef UART_LOOPBACK_EN
  logic loopback;
`endif

  uart_cfg_if #(.DVSR_W(16)) bus ();

  uart_cfg #(.DVSR_W(16), .FIFO_W(2), .SB_TCK(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rx       (rx),
    .tx       (tx)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback (loopback)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [7:0] rx_q[$];
  bit auto_rd = 1'b1;
  logic tx_log[$];
  logic exp_wave[$];
  bit rec = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every byte the DUT presents is compared with the queue head and popped.
  initial begin
    logic [7:0] exp_b;
    bus.rd_uart = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && auto_rd && bus.rx_empty === 1'b0) begin
        if (rx_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL rx_unexpected: got %0h expected none", bus.r_data);
        end else begin
          exp_b = rx_q.pop_front();
          check("rx_byte", 32'(bus.r_data), 32'(exp_b));
        end
        bus.rd_uart = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_uart = 1'b0;
      end
    end
  end

  always @(negedge clk) if (rec) tx_log.push_back(tx);

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input logic [7:0] d);
    bus.wr_uart = 1'b1;
    bus.w_data  = d;
    cyc(1);
    bus.wr_uart = 1'b0;
  endtask

  task automatic add_frame(input logic [7:0] d, input int nb, input bit pe, input bit pb, input int nstop);
    repeat (64) exp_wave.push_back(1'b0);
    for (int i = 0; i < nb; i++) repeat (64) exp_wave.push_back(d[i]);
    if (pe) repeat (64) exp_wave.push_back(pb);
    repeat (64 * nstop) exp_wave.push_back(1'b1);
  endtask

  task automatic tx_compare(input string name);
    int k;
    int bad;
    k = -1;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] == 1'b0) begin
        k = i;
        break;
      end
    end
    if (k < 0 || k + exp_wave.size() + 1 > tx_log.size()) begin
      vecs++;
      errs++;
      $display("FAIL %s_frame: got start %0d log %0d expected full frame", name, k, tx_log.size());
      return;
    end
    for (int s = 0; s < exp_wave.size() / 64; s++) begin
      bad = 0;
      for (int j = 0; j < 64; j++) if (tx_log[k + s * 64 + j] !== exp_wave[s * 64 + j]) bad++;
      check($sformatf("%s_seg%0d_badsamples", name, s), 32'(bad), 32'd0);
    end
    bad = 0;
    for (int i = k + exp_wave.size(); i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) bad++;
    check($sformatf("%s_trail_badsamples", name), 32'(bad), 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input int nb, input bit pe, input bit pb, input bit stop_lo);
    rx = 1'b0;
    cyc(64);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      cyc(64);
    end
    if (pe) begin
      rx = pb;
      cyc(64);
    end
    if (stop_lo) begin
      rx = 1'b0;
      cyc(40);
      rx = 1'b1;
      cyc(24);
    end else begin
      rx = 1'b1;
      cyc(64);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || bus.rx_empty !== 1'b1) && n < 3000) begin
      cyc(1);
      n++;
    end
    check(name, 32'(rx_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset          = 1'b1;
    rx             = 1'b1;
    bus.dvsr       = 16'd4;
    bus.data_bits  = 2'b11;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.stop2      = 1'b0;
    bus.wr_uart    = 1'b0;
    bus.w_data     = 8'h00;
    bus.clr_err    = 1'b0;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    cyc(2);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
    check("rst_tx_full", 32'(bus.tx_full), 32'd0);
    check("rst_r_data", 32'(bus.r_data), 32'h00);
    check("rst_err_frame", 32'(bus.err_frame), 32'd0);
    check("rst_err_parity", 32'(bus.err_parity), 32'd0);
    check("rst_err_overrun", 32'(bus.err_overrun), 32'd0);
    reset = 1'b0;
    cyc(3);

    // TX 8N1: A5 then four queued bytes fill the FIFO; a fifth write is dropped.
    tx_log.delete();
    exp_wave.delete();
    rec = 1'b1;
    write_tx(8'hA5);
    cyc(10);
    write_tx(8'h11);
    write_tx(8'h22);
    write_tx(8'h33);
    write_tx(8'h44);
    check("tx_full_after_4", 32'(bus.tx_full), 32'd1);
    write_tx(8'h55);
    check("tx_full_after_drop", 32'(bus.tx_full), 32'd1);
    cyc(3500);
    rec = 1'b0;
    add_frame(8'hA5, 8, 0, 0, 1);
    add_frame(8'h11, 8, 0, 0, 1);
    add_frame(8'h22, 8, 0, 0, 1);
    add_frame(8'h33, 8, 0, 0, 1);
    add_frame(8'h44, 8, 0, 0, 1);
    tx_compare("tx8n1");
    check("tx_full_drained", 32'(bus.tx_full), 32'd0);

    // TX 8N2 back to back: each stop lasts 128 cycles, next start follows with no gap.
    bus.stop2 = 1'b1;
    tx_log.delete();
    exp_wave.delete();
    rec = 1'b1;
    write_tx(8'hA5);
    write_tx(8'h3C);
    cyc(1700);
    rec = 1'b0;
    add_frame(8'hA5, 8, 0, 0, 2);
    add_frame(8'h3C, 8, 0, 0, 2);
    tx_compare("tx8n2");
    bus.stop2 = 1'b0;

    // RX 7E1: 0x41 has two ones, so the even parity bit is 0.
    bus.data_bits = 2'b10;
    bus.parity_en = 1'b1;
    rx_q.push_back(8'h41);
    rx_frame(8'h41, 7, 1, 0, 0);
    wait_drain("rx7e1_drain");
    check("rx7e1_err_parity", 32'(bus.err_parity), 32'd0);
    check("rx7e1_err_frame", 32'(bus.err_frame), 32'd0);
    rx_q.push_back(8'h41);
    rx_frame(8'h41, 7, 1, 1, 0);
    wait_drain("rx7e1_bad_drain");
    check("rx7e1_bad_err_parity", 32'(bus.err_parity), 32'd1);
    check("rx7e1_bad_err_frame", 32'(bus.err_frame), 32'd0);
    pulse_clr();
    check("clr_err_parity", 32'(bus.err_parity), 32'd0);

    // Overrun: five bytes into a four-deep FIFO with no reads.
    bus.data_bits = 2'b11;
    bus.parity_en = 1'b0;
    auto_rd = 1'b0;
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 8, 0, 0, 0);
    check("ovr_rx_empty", 32'(bus.rx_empty), 32'd0);
    check("ovr_err_overrun", 32'(bus.err_overrun), 32'd1);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h04);
    auto_rd = 1'b1;
    wait_drain("ovr_drain");
    check("ovr_sticky", 32'(bus.err_overrun), 32'd1);
    pulse_clr();
    check("clr_err_overrun", 32'(bus.err_overrun), 32'd0);

    // Framing error: stop bit low, byte still stored.
    rx_q.push_back(8'h3C);
    rx_frame(8'h3C, 8, 0, 0, 1);
    cyc(100);
    wait_drain("frm_drain");
    check("frm_err_frame", 32'(bus.err_frame), 32'd1);
    pulse_clr();
    check("clr_err_frame", 32'(bus.err_frame), 32'd0);

    // Glitch: two ticks low is rejected at the start-bit centre.
    rx = 1'b0;
    cyc(8);
    rx = 1'b1;
    cyc(200);
    check("glitch_rx_empty", 32'(bus.rx_empty), 32'd1);
    rx_q.push_back(8'h5A);
    rx_frame(8'h5A, 8, 0, 0, 0);
    wait_drain("post_glitch_drain");

`ifdef UART_LOOPBACK_EN
    // Loopback 6O2: 0x2A -> 101010 has three ones, odd parity bit is 0.
    begin
      int lows;
      lows = 0;
      loopback       = 1'b1;
      bus.data_bits  = 2'b01;
      bus.parity_en  = 1'b1;
      bus.parity_odd = 1'b1;
      bus.stop2      = 1'b1;
      rx_q.push_back(8'h2A);
      write_tx(8'h2A);
      repeat (900) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
      end
      check("lb_tx_pin_lows", 32'(lows), 32'd0);
      wait_drain("lb_drain");
      check("lb_err_parity", 32'(bus.err_parity), 32'd0);
      check("lb_err_frame", 32'(bus.err_frame), 32'd0);
      loopback = 1'b0;
    end
`endif

    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
